// File: rtl/moore_pattern_controller_if.sv
// Serial bit handshake between the stimulus logic and the pattern controller.
//   inputX      : serial data bit (master -> slave)
//   inputValid  : inputX is valid this cycle (master -> slave)
//   outputReady : controller accepts a bit this cycle (slave -> master)
// A bit transfers on a rising clock edge when inputValid & outputReady.
interface moore_pattern_controller_if;
  logic inputX;
  logic inputValid;
  logic outputReady;

  modport master (output inputX, output inputValid, input outputReady);
  modport slave  (input inputX, input inputValid, output outputReady);
endinterface

// File: rtl/moore_pattern_controller.sv
// Moore controller for a 3-bit serial pattern detector with a 2-bit state
// register and a saturating match counter.
//   inputClk    : clock, rising edge
//   inputR      : asynchronous active-low reset
//   inputEn     : step enable; 0 blocks acceptance of bits
//   inputClear  : synchronous clear of state and counter (beats a valid bit)
//   bus         : serial bit handshake (slave side)
//   outputy1/2  : registered state bits (MSB/LSB)
//   outputZ     : 1 iff state == S3 (full pattern seen)
//   outputCount : completed matches, saturating at all-ones
module moore_pattern_controller #(
  parameter logic [2:0]  PATTERN = 3'b101,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         inputClk,
  input  logic                         inputR,
  input  logic                         inputEn,
  input  logic                         inputClear,
  moore_pattern_controller_if.slave    bus,
  output logic                         outputy1,
  output logic                         outputy2,
  output logic                         outputZ,
  output logic [CNT_W-1:0]             outputCount
);

  // State value equals the length of the matched PATTERN prefix.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Longest suffix of (k-bit prefix of PATTERN, then x) that is itself a
  // prefix of PATTERN. q[0] is the oldest bit, q[k] the newest.
  function automatic logic [1:0] nextOf(input int unsigned k, input logic x);
    logic [3:0]  q;
    int unsigned n;
    int unsigned lStart;
    logic        hit;
    logic        ok;
    logic [1:0]  res;
    q   = '0;
    res = 2'b00;
    hit = 1'b0;
    for (int unsigned j = 0; j < k; j++) q[j] = PATTERN[2-j];
    q[k]   = x;
    n      = k + 1;
    lStart = (n > 3) ? 3 : n;
    for (int unsigned l = lStart; l >= 1; l--) begin
      if (!hit) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < l; j++)
          if (q[n-l+j] != PATTERN[2-j]) ok = 1'b0;
        if (ok) begin
          hit = 1'b1;
          res = 2'(l);
        end
      end
    end
    return res;
  endfunction

  // Transition table indexed by {state, x}; two bits per entry. Without
  // overlap, S3 behaves like S0 for the next bit.
  function automatic logic [15:0] buildTable();
    logic [15:0] t;
    t = '0;
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned x = 0; x < 2; x++)
        t[(2*k+x)*2 +: 2] = nextOf((k == 3 && !OVERLAP) ? 0 : k, x[0]);
    return t;
  endfunction

  localparam logic [15:0] NEXT_TBL = buildTable();

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic             ready;
  logic             accept;
  logic [2:0]       idx;

  assign ready           = inputR & inputEn & ~inputClear;
  assign bus.outputReady = ready;

  always_ff @(posedge inputClk or negedge inputR) begin
    if (!inputR) begin
      state <= S0;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    accept    = bus.inputValid & ready;
    idx       = {state, bus.inputX};
    if (inputClear) begin
      stateNext = S0;
      countNext = '0;
    end else if (accept) begin
      // Lookup only on acceptance so an unknown idle inputX cannot leak in.
      stateNext = state_t'(NEXT_TBL[{idx, 1'b0} +: 2]);
      if (stateNext == S3 && count != '1) countNext = count + 1'b1;
    end
    outputy1    = state[1];
    outputy2    = state[0];
    outputZ     = (state == S3);
    outputCount = count;
  end

endmodule

// File: tb/tb_moore_pattern_controller.sv
module tb_moore_pattern_controller;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic x = 1'b0;
  logic valid = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  moore_pattern_controller_if busA ();
  moore_pattern_controller_if busB ();
  moore_pattern_controller_if busC ();

  assign busA.inputX = x;  assign busA.inputValid = valid;
  assign busB.inputX = x;  assign busB.inputValid = valid;
  assign busC.inputX = x;  assign busC.inputValid = valid;

  logic       yA1, yA2, zA, yB1, yB2, zB, yC1, yC2, zC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;

  moore_pattern_controller #(.PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dutA (
    .inputClk(clk), .inputR(rstn), .inputEn(en), .inputClear(clr), .bus(busA),
    .outputy1(yA1), .outputy2(yA2), .outputZ(zA), .outputCount(cntA));

  moore_pattern_controller #(.PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dutB (
    .inputClk(clk), .inputR(rstn), .inputEn(en), .inputClear(clr), .bus(busB),
    .outputy1(yB1), .outputy2(yB2), .outputZ(zB), .outputCount(cntB));

  moore_pattern_controller #(.PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)) dutC (
    .inputClk(clk), .inputR(rstn), .inputEn(en), .inputClear(clr), .bus(busC),
    .outputy1(yC1), .outputy2(yC2), .outputZ(zC), .outputCount(cntC));

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    valid = 1'b1;
    x     = b;
    cycle();
    valid = 1'b0;
  endtask

  // Test 1/2 expectations for stream 1,0,1,0,1
  logic [1:0] expA [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
  logic       expZA[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] expCA[5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
  logic [1:0] expB [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
  logic       expZB[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] expCB[5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
  logic [1:0] strm [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] expCnt4[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [1:0] expSt4 [6] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};

  initial begin
    // Reset state
    cycle();
    checkVal("rst_state", {yA1, yA2}, 2'b00);
    checkVal("rst_z", zA, 1'b0);
    checkVal("rst_cnt", cntA, 8'd0);
    checkVal("rst_ready", busA.outputReady, 1'b0);
    rstn = 1'b1;
    #1;
    checkVal("ready_idle", busA.outputReady, 1'b1);

    // Tests 1 and 2: overlap vs non-overlap on the same stream
    for (int i = 0; i < 5; i++) begin
      sendBit(strm[i][0]);
      checkVal($sformatf("t1_state%0d", i), {yA1, yA2}, expA[i]);
      checkVal($sformatf("t1_z%0d", i), zA, expZA[i]);
      checkVal($sformatf("t1_cnt%0d", i), cntA, expCA[i]);
      checkVal($sformatf("t2_state%0d", i), {yB1, yB2}, expB[i]);
      checkVal($sformatf("t2_z%0d", i), zB, expZB[i]);
      checkVal($sformatf("t2_cnt%0d", i), cntB, expCB[i]);
    end

    // Test 4: saturation on PATTERN=111, CNT_W=2
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checkVal("t4_clr_cnt", cntC, 2'd0);
    for (int i = 0; i < 6; i++) begin
      sendBit(1'b1);
      checkVal($sformatf("t4_cnt%0d", i), cntC, expCnt4[i]);
      checkVal($sformatf("t4_state%0d", i), {yC1, yC2}, expSt4[i]);
    end

    // Test 3: handshake gating on dutA
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checkVal("t3_clr_state", {yA1, yA2}, 2'b00);
    sendBit(1'b1);
    sendBit(1'b0);
    checkVal("t3_s2", {yA1, yA2}, 2'b10);
    x = 1'bx;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkVal($sformatf("t3_novalid%0d", i), {yA1, yA2}, 2'b10);
    end
    en = 1'b0;
    valid = 1'b1;
    x = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkVal($sformatf("t3_ready_en0_%0d", i), busA.outputReady, 1'b0);
      cycle();
      checkVal($sformatf("t3_hold%0d", i), {yA1, yA2}, 2'b10);
      checkVal($sformatf("t3_holdz%0d", i), zA, 1'b0);
    end
    valid = 1'b0;
    en = 1'b1;
    sendBit(1'b1);
    checkVal("t3_s3", {yA1, yA2}, 2'b11);
    checkVal("t3_z", zA, 1'b1);
    checkVal("t3_cnt", cntA, 8'd1);

    // Test 5: clear beats a valid bit while in S2
    sendBit(1'b0);
    checkVal("t5_s2", {yA1, yA2}, 2'b10);
    clr = 1'b1;
    valid = 1'b1;
    x = 1'b1;
    #1;
    checkVal("t5_ready", busA.outputReady, 1'b0);
    cycle();
    clr = 1'b0;
    valid = 1'b0;
    checkVal("t5_state", {yA1, yA2}, 2'b00);
    checkVal("t5_cnt", cntA, 8'd0);
    checkVal("t5_z", zA, 1'b0);

    // Test 6: async reset from S2 with count 5
    sendBit(1'b1);
    for (int i = 0; i < 5; i++) begin
      sendBit(1'b0);
      sendBit(1'b1);
    end
    sendBit(1'b0);
    checkVal("t6_pre_state", {yA1, yA2}, 2'b10);
    checkVal("t6_pre_cnt", cntA, 8'd5);
    #2;
    rstn = 1'b0;
    #1;
    checkVal("t6_async_state", {yA1, yA2}, 2'b00);
    checkVal("t6_async_z", zA, 1'b0);
    checkVal("t6_async_cnt", cntA, 8'd0);
    #1;
    rstn = 1'b1;
    sendBit(1'b1);
    checkVal("t6_first", {yA1, yA2}, 2'b01);
    sendBit(1'b0);
    sendBit(1'b1);
    checkVal("t6_cnt", cntA, 8'd1);
    checkVal("t6_z", zA, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moore_pattern_controller.md
Name: moore_pattern_controller

Overview:
- Moore-style controller that sequences the team's 2-bit state-register stage.
- Consumes a serial bit stream under a valid/ready handshake and computes next state for a 3-bit pattern detector, including the state register.
- Exposes the state bits, a Moore match output and a saturating match counter.
- Sits between the stimulus/input logic and display or counting logic in the Moore exercise designs.

Parameters:
- PATTERN, 3'b101, bit pattern to detect; PATTERN[2] is received first.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = detection restarts from S0 after a match.
- CNT_W, 8, width of the match counter.

Ports:
- inputClk  in  1  clock; all state changes on the rising edge.
- inputR  in  1  reset, asynchronous, active-low.
- inputEn  in  1  step enable; when 0, the controller accepts no bits.
- inputClear  in  1  synchronous clear of state and counter.
- inputX  in  1  serial data bit.
- inputValid  in  1  inputX is valid this cycle.
- outputReady  out  1  controller can accept a bit this cycle.
- outputy1  out  1  state bit, MSB.
- outputy2  out  1  state bit, LSB.
- outputZ  out  1  Moore output; 1 iff state == S3.
- outputCount  out  CNT_W  number of completed matches, saturating.

Behaviour:
- Reset: while inputR=0, asynchronously force state=S0 (y1y2=00), outputZ=0, outputCount=0. outputReady=0 while inputR=0.
- State encoding (y1y2):
  - S0=00: no prefix matched.
  - S1=01: PATTERN[2] matched.
  - S2=10: PATTERN[2:1] matched.
  - S3=11: full pattern matched.
- outputReady = inputR & inputEn & ~inputClear (combinational).
- Accept when inputValid & outputReady at a rising edge. At most one bit per cycle. When no bit is accepted, state and counter hold.
- Next state:
  - S0..S2: next = longest suffix of (matched prefix followed by inputX) that is a prefix of PATTERN.
  - S3 with OVERLAP=1: same rule, applied to the full pattern followed by inputX.
  - S3 with OVERLAP=0: next = the transition from S0 on inputX.
  - Transition table is fixed at elaboration from PATTERN and OVERLAP; no runtime configuration.
- Example, PATTERN=101, OVERLAP=1:
  - S0: 0→S0, 1→S1.
  - S1: 0→S2, 1→S1.
  - S2: 0→S0, 1→S3.
  - S3: 0→S2, 1→S1.
- Latency:
  - outputy1/outputy2 are registered and show the new state the cycle after acceptance.
  - outputZ is decoded from registered state only (Moore), so it rises 1 cycle after the accepting edge of the final pattern bit.
- Counter:
  - Increments on the same edge that transitions into S3, including S3→S3 for self-overlapping patterns such as 111.
  - Saturates at 2^CNT_W−1; no wrap.
- Clear: inputClear=1 at an edge sets state=S0 and count=0. Clear has priority over a simultaneous valid bit; that bit is not accepted, and ready=0 in that cycle already signals this.
- Reset mid-sequence: the partial prefix is discarded. After release, detection restarts from S0, and the first accept can occur on the first edge with inputR=1.
- inputEn=0 freezes state, count and outputZ regardless of inputValid.
- Unknown inputX while not accepted must not affect state.

Test Plan:
1. PATTERN=101, OVERLAP=1; accept bits 1,0,1,0,1 on consecutive edges → y1y2 sequence 01,10,11,10,11; outputZ=1 in cycles after bits 3 and 5; outputCount=2.
2. PATTERN=101, OVERLAP=0; same stream → y1y2 01,10,11,00,01; outputCount=1; outputZ=1 only after bit 3.
3. Handshake gating: bits 1,0 accepted, then inputValid=0 for 3 cycles, then inputEn=0 with inputValid=1 and inputX=1 for 2 cycles → state holds 10 and ready=0 while En=0; re-enable, accept 1 → S3, count=1.
4. Saturation: CNT_W=2, PATTERN=111, OVERLAP=1; accept six 1s → count 0,0,1,2,3,3; state stays 11 from bit 3 onward.
5. Clear priority: in S2, assert inputClear with inputValid=1 and inputX=1 → next state 00, count 0, ready=0 that cycle, no match counted.
6. Async reset: in S2 with count=5, pull inputR low mid-cycle → y1y2=00, Z=0, count=0 immediately, no clock needed; release, accept 1,0,1 → count=1.
